// File: rtl/ser4_tx.sv
// ser4_tx: N:1 LSB-first serializer with word clock and frame strobe.
// Idle words fill gaps and training words are sent on request; it flags stream underruns and counts data words.
module ser4_tx #(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] IDLE_WORD  = '0,
    parameter logic [WIDTH-1:0] TRAIN_WORD = WIDTH'(4'b0011)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             train_i,
    input  logic             clr_i,
    output logic             ser_o,
    output logic             pclk_o,
    output logic             frame_o,
    output logic             underrun_o,
    output logic [15:0]      words_o
);

    localparam int             CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  HALF = CW'(WIDTH / 2);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             active_q, active_d;
    logic             underrun_q, underrun_d;
    logic [15:0]      words_q, words_d;

    logic load;
    logic accept;
    logic underrun_set;

    always_comb begin
        cnt_d        = cnt_q;
        sh_d         = sh_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        active_d     = active_q;
        words_d      = words_q;
        underrun_set = 1'b0;

        load   = (cnt_q == LAST);
        accept = valid_i && !hold_full_q;

        if (!load) begin
            cnt_d = cnt_q + 1'b1;
            sh_d  = {1'b0, sh_q[WIDTH-1:1]};
        end else begin
            cnt_d = '0;
            if (train_i) begin
                // Training preempts data but leaves any held word waiting.
                sh_d     = TRAIN_WORD;
                active_d = 1'b0;
            end else if (hold_full_q) begin
                sh_d        = hold_q;
                hold_full_d = 1'b0;
                active_d    = 1'b1;
                words_d     = words_q + 16'd1;
            end else begin
                sh_d         = IDLE_WORD;
                underrun_set = active_q;
                active_d     = 1'b0;
            end
        end

        // No bypass: hold is only refilled when it was already empty before this edge.
        if (accept) begin
            hold_d      = data_i;
            hold_full_d = 1'b1;
        end

        underrun_d = underrun_set | (underrun_q & ~clr_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            sh_q        <= IDLE_WORD;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            active_q    <= 1'b0;
            underrun_q  <= 1'b0;
            words_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            active_q    <= active_d;
            underrun_q  <= underrun_d;
            words_q     <= words_d;
        end
    end

    assign ser_o      = sh_q[0];
    assign frame_o    = (cnt_q == '0);
    assign pclk_o     = (cnt_q < HALF);
    assign ready_o    = !hold_full_q;
    assign underrun_o = underrun_q;
    assign words_o    = words_q;

endmodule

// File: tb/tb_ser4_tx.sv
// Bench for ser4_tx: word-level reference model checked every cycle, plus directed
// scenarios with hand-computed serial patterns and randomized traffic.
module tb_ser4_tx;
    localparam int         W     = 4;
    localparam logic [3:0] IDLE  = 4'h0;
    localparam logic [3:0] TRAIN = 4'b0011;
    localparam int         HN    = 8192;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic [3:0]  data_i  = '0;
    logic        valid_i = 1'b0;
    logic        train_i = 1'b0;
    logic        clr_i   = 1'b0;
    logic        ready_o, ser_o, pclk_o, frame_o, underrun_o;
    logic [15:0] words_o;

    ser4_tx #(.WIDTH(W), .IDLE_WORD(IDLE), .TRAIN_WORD(TRAIN)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .train_i(train_i), .clr_i(clr_i), .ser_o(ser_o), .pclk_o(pclk_o),
        .frame_o(frame_o), .underrun_o(underrun_o), .words_o(words_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: current word plus bit position, a pending-word queue.
    logic [3:0]  m_cur;
    int          m_pos;
    logic [3:0]  m_hold[$];
    bit          m_active, m_under, m_live = 1'b0;
    logic [15:0] m_words;

    always @(posedge clk) begin : model
        bit acc, set_u;
        if (rst) begin
            m_cur = IDLE; m_pos = 0; m_hold.delete();
            m_active = 0; m_under = 0; m_words = '0; m_live = 1;
        end else begin
            acc   = valid_i && (m_hold.size() == 0);
            set_u = 0;
            if (m_pos == W - 1) begin
                m_pos = 0;
                if (train_i) begin
                    m_cur = TRAIN; m_active = 0;
                end else if (m_hold.size() != 0) begin
                    m_cur = m_hold.pop_front(); m_active = 1; m_words = m_words + 16'd1;
                end else begin
                    m_cur = IDLE; set_u = m_active; m_active = 0;
                end
            end else begin
                m_pos = m_pos + 1;
            end
            if (acc) m_hold.push_back(data_i);
            if (set_u) m_under = 1;
            else if (clr_i) m_under = 0;
        end
    end

    // Per-cycle history log and model comparison, sampled 2 time units after the edge.
    int          cyc = 0;
    logic        h_ser[HN], h_frame[HN], h_ready[HN], h_und[HN];
    logic [15:0] h_words[HN];

    always @(posedge clk) begin
        #2;
        if (cyc < HN) begin
            h_ser[cyc] = ser_o; h_frame[cyc] = frame_o; h_ready[cyc] = ready_o;
            h_und[cyc] = underrun_o; h_words[cyc] = words_o;
        end
        cyc++;
        if (m_live) begin
            check("ser",      ser_o,      m_cur[m_pos]);
            check("frame",    frame_o,    m_pos == 0);
            check("pclk",     pclk_o,     m_pos < W / 2);
            check("ready",    ready_o,    m_hold.size() == 0);
            check("underrun", underrun_o, m_under);
            check("words",    words_o,    m_words);
        end
    end

    function automatic logic [31:0] hbits(input int start, input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++)
            if (start + i >= 0 && start + i < HN) v[i] = h_ser[start + i];
        return v;
    endfunction

    function automatic logic hany(input int start, input int n, input int which);
        logic r;
        r = 1'b0;
        for (int i = 0; i < n; i++)
            if (start + i >= 0 && start + i < HN)
                r = r | ((which == 0) ? h_und[start + i] : h_ready[start + i]);
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; valid_i = 1'b0; train_i = 1'b0; clr_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        @(negedge clk);
        while (!frame_o && n < 16) begin @(negedge clk); n++; end
        check("sync_frame", frame_o, 1);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [3:0] d);
        int n;
        n = 0;
        data_i = d; valid_i = 1'b1;
        while (!ready_o && n < 50) begin @(negedge clk); n++; end
        check("send_timeout", n < 50, 1);
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ser"},   ser_o,      0);
        check({tag, "_pclk"},  pclk_o,     1);
        check({tag, "_frame"}, frame_o,    1);
        check({tag, "_ready"}, ready_o,    1);
        check({tag, "_und"},   underrun_o, 0);
        check({tag, "_words"}, words_o,    0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a, t;
        logic [7:0] pat;

        // Reset values and word-clock pattern
        do_reset();
        check_reset_values("reset");
        for (int i = 0; i < 8; i++) begin pat[i] = pclk_o; @(negedge clk); end
        check("pclk_pattern", pat, 8'h33);

        // Single word accepted at cnt=1: bit 0 three cycles after the accept cycle
        do_reset();
        @(negedge clk);
        a = cyc - 1;
        send(4'hA);
        repeat (8) @(negedge clk);
        check("single_frame", h_frame[a+3], 1);
        check("single_bits",  hbits(a + 3, 4), 4'hA);
        check("single_words", h_words[a+3], 1);
        check("single_und_before", h_und[a+6], 0);
        check("single_und_after",  h_und[a+7], 1);

        // Back-to-back stream 1,2,3
        do_reset();
        a = cyc - 1;
        send(4'h1); send(4'h2); send(4'h3);
        repeat (20) @(negedge clk);
        check("stream_ready_drop", h_ready[a+1], 0);
        check("stream_frame", h_frame[a+4], 1);
        check("stream_bits",  hbits(a + 4, 12), 12'h321);
        check("stream_und_during", hany(a + 4, 12, 0), 0);
        check("stream_und_end", h_und[a+16], 1);
        check("stream_words", h_words[a+15], 3);

        // Training preempts a held word for three words
        do_reset();
        send(4'h5);
        train_i = 1'b1;
        t = cyc - 1;
        repeat (12) @(negedge clk);
        train_i = 1'b0;
        repeat (10) @(negedge clk);
        check("train_bits", hbits(t + 3, 16), 16'h5333);
        check("train_ready_low", hany(t, 15, 1), 0);
        check("train_ready_back", h_ready[t+15], 1);
        check("train_und_low", hany(t, 19, 0), 0);
        check("train_words", h_words[t+15], 1);
        check("train_und_after", h_und[t+19], 1);

        // Accept on a load edge: one idle word, then data five cycles later
        do_reset();
        repeat (3) @(negedge clk);
        a = cyc - 1;
        send(4'h6);
        repeat (10) @(negedge clk);
        check("late_idle_frame", h_frame[a+1], 1);
        check("late_idle_bits",  hbits(a + 1, 4), 4'h0);
        check("late_frame", h_frame[a+5], 1);
        check("late_bits",  hbits(a + 5, 4), 4'h6);

        // clr_i coinciding with an underrun set: set wins; later clr clears
        do_reset();
        send(4'h9);
        repeat (6) @(negedge clk);
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        check("clr_vs_set", underrun_o, 1);
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        check("clr_clears", underrun_o, 0);

        // Word counter wraps from 0xFFFF
        do_reset();
        repeat (2) @(negedge clk);
        force dut.words_q = 16'hFFFF;
        m_words = 16'hFFFF;
        @(negedge clk);
        release dut.words_q;
        @(negedge clk);
        check("wrap_preload", words_o, 16'hFFFF);
        wait_frame();
        a = cyc - 1;
        send(4'hC);
        repeat (8) @(negedge clk);
        check("wrap_before", h_words[a+3], 16'hFFFF);
        check("wrap_after",  h_words[a+4], 16'h0000);

        // Reset at cnt=2 with a word held: the word is dropped
        do_reset();
        a = cyc - 1;
        send(4'hF);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("midrst");
        repeat (14) @(negedge clk);
        check("midrst_dropped", hbits(a + 3, 12), 12'h000);

        // Randomized traffic, checked by the model every cycle
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            valid_i = ($urandom_range(0, 99) < 65);
            data_i  = 4'($urandom);
            train_i = ($urandom_range(0, 99) < 8);
            clr_i   = ($urandom_range(0, 99) < 5);
            rst     = ($urandom_range(0, 999) < 5);
            @(negedge clk);
        end
        rst = 1'b0; valid_i = 1'b0; train_i = 1'b0; clr_i = 1'b0;
        repeat (8) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
